// File: rtl/dm_dp_clr.sv
// Dual-port data memory (port A CPU read/write, port B read-only) with a built-in clear engine.
// Optional byte write enables on port A when DM_BYTE_WE_EN is defined.
module dm_dp_clr #(
    parameter int unsigned   DW      = 16,
    parameter int unsigned   DEPTH   = 8192,
    parameter int unsigned   AW      = 13,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     a_addr,
    input  logic              a_re,
    input  logic              a_we,
    input  logic [DW-1:0]     a_wdata,
`ifdef DM_BYTE_WE_EN
    input  logic [DW/8-1:0]   a_be,
`endif
    output logic [DW-1:0]     a_rdata,
    output logic              a_err,
    input  logic [AW-1:0]     b_addr,
    input  logic              b_re,
    output logic [DW-1:0]     b_rdata,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);

`ifdef DM_BYTE_WE_EN
    localparam int unsigned NB = DW / 8;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [DW-1:0] r_mem [0:DEPTH-1];

    logic [DW-1:0] r_a_rdata;
    logic [DW-1:0] r_b_rdata;
    logic          r_a_err;
    logic          r_busy;
    logic          r_clr_done;

    logic          w_a_svc;
    logic          w_a_in_rng;
    logic          w_b_in_rng;
    logic          w_a_rd;
    logic          w_a_wr;
    logic          w_a_err;
    logic          w_clr_wr;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [DW-1:0] w_wr_data;
    logic [DW-1:0] w_a_old;
    logic [DW-1:0] w_a_merge;
    logic [DW-1:0] w_b_word;

    assign a_rdata  = r_a_rdata;
    assign b_rdata  = r_b_rdata;
    assign a_err    = r_a_err;
    assign busy     = r_busy;
    assign clr_done = r_clr_done;

    // State register
    always_ff @(negedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; port A is only served outside CLEAR
    always_comb begin
        w_state_nxt = r_state;
        w_a_svc     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_a_svc = 1'b1;
                if (clr_req) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (r_cnt == AW'(DEPTH - 1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_a_svc     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_a_in_rng = 32'(a_addr) < DEPTH;
    assign w_b_in_rng = 32'(b_addr) < DEPTH;

    assign w_a_rd   = w_a_svc & a_re & ~a_we;
    assign w_a_wr   = w_a_svc & a_we & ~a_re & w_a_in_rng;
    assign w_a_err  = w_a_svc ? (a_re & a_we) : (a_re | a_we);
    assign w_clr_wr = (r_state == S_CLEAR);

    assign w_a_old = w_a_in_rng ? r_mem[a_addr] : '0;

`ifdef DM_BYTE_WE_EN
    // Keep unselected bytes from the stored word
    always_comb begin
        w_a_merge = w_a_old;
        for (int i = 0; i < NB; i++) begin
            if (a_be[i]) begin
                w_a_merge[i*8 +: 8] = a_wdata[i*8 +: 8];
            end
        end
    end
`else
    assign w_a_merge = a_wdata;
`endif

    // Single array write port shared by the clear engine and port A
    assign w_wr_en   = ~rst & (w_clr_wr | w_a_wr);
    assign w_wr_addr = w_clr_wr ? r_cnt : a_addr;
    assign w_wr_data = w_clr_wr ? CLR_VAL : w_a_merge;

    // Port B sees a same-edge write to its address (write-first)
    assign w_b_word = !w_b_in_rng                         ? '0 :
                      (w_wr_en && (w_wr_addr == b_addr))  ? w_wr_data :
                                                            r_mem[b_addr];

    always_ff @(negedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
            r_a_err    <= 1'b0;
            r_busy     <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_cnt      <= w_clr_wr ? (r_cnt + AW'(1)) : '0;
            r_a_err    <= w_a_err;
            r_busy     <= (w_state_nxt == S_CLEAR);
            r_clr_done <= (w_state_nxt == S_DONE);
            if (w_a_rd) begin
                r_a_rdata <= w_a_old;
            end
            if (b_re) begin
                r_b_rdata <= w_b_word;
            end
        end
    end

endmodule

// File: tb/tb_dm_dp_clr.sv
// Bench for dm_dp_clr: small-depth instance, behavioural model checked every cycle plus literal checks.
module tb_dm_dp_clr;
    localparam int unsigned   DW      = 16;
    localparam int unsigned   DEPTH   = 20;
    localparam int unsigned   AW      = 5;
    localparam logic [DW-1:0] CLR_VAL = 16'hA5A5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] a_addr;
    logic          a_re;
    logic          a_we;
    logic [DW-1:0] a_wdata;
`ifdef DM_BYTE_WE_EN
    logic [DW/8-1:0] a_be;
`endif
    logic [DW-1:0] a_rdata;
    logic          a_err;
    logic [AW-1:0] b_addr;
    logic          b_re;
    logic [DW-1:0] b_rdata;
    logic          clr_req;
    logic          busy;
    logic          clr_done;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    dm_dp_clr #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .CLR_VAL(CLR_VAL)) dut (
        .clk(clk), .rst(rst),
        .a_addr(a_addr), .a_re(a_re), .a_we(a_we), .a_wdata(a_wdata),
`ifdef DM_BYTE_WE_EN
        .a_be(a_be),
`endif
        .a_rdata(a_rdata), .a_err(a_err),
        .b_addr(b_addr), .b_re(b_re), .b_rdata(b_rdata),
        .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: clear progress is a word index, -1 when no clear is running
    logic [DW-1:0] mm [DEPTH];
    logic [DW-1:0] m_ar = '0;
    logic [DW-1:0] m_br = '0;
    logic          m_err = 1'b0;
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    int            m_clr_idx = -1;

    always @(negedge clk) begin
        bit            wr;
        bit            done_now;
        int            waddr;
        int            aa;
        int            ba;
        logic [DW-1:0] wval;
        wr = 0; waddr = 0; wval = '0; done_now = 0;
        aa = int'(a_addr);
        ba = int'(b_addr);
        if (rst) begin
            m_ar = '0; m_br = '0; m_err = 0; m_busy = 0; m_done = 0; m_clr_idx = -1;
        end else begin
            if (m_clr_idx >= 0) begin
                wr = 1; waddr = m_clr_idx; wval = CLR_VAL;
                m_err = a_re || a_we;
            end else begin
                m_err = a_re && a_we;
                if (a_we && !a_re && aa < int'(DEPTH)) begin
                    wr = 1; waddr = aa; wval = a_wdata;
`ifdef DM_BYTE_WE_EN
                    for (int k = 0; k < int'(DW/8); k++)
                        if (!a_be[k]) wval[k*8 +: 8] = mm[aa][k*8 +: 8];
`endif
                end else if (a_re && !a_we) begin
                    m_ar = (aa < int'(DEPTH)) ? mm[aa] : '0;
                end
            end
            if (b_re) m_br = (ba >= int'(DEPTH)) ? '0 : (wr && waddr == ba) ? wval : mm[ba];
            if (wr) mm[waddr] = wval;
            if (m_clr_idx >= 0) begin
                if (m_clr_idx == int'(DEPTH) - 1) begin m_clr_idx = -1; done_now = 1; end
                else m_clr_idx++;
            end else if (clr_req && !m_done) begin
                m_clr_idx = 0;
            end
            m_busy = (m_clr_idx >= 0);
            m_done = done_now;
        end
    end

    // Compare every cycle, half a period after the active edge
    always @(posedge clk) begin
        if (chk_en) begin
            cmp("a_rdata",  32'(a_rdata),  32'(m_ar));
            cmp("b_rdata",  32'(b_rdata),  32'(m_br));
            cmp("a_err",    32'(a_err),    32'(m_err));
            cmp("busy",     32'(busy),     32'(m_busy));
            cmp("clr_done", 32'(clr_done), 32'(m_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        a_re = 0; a_we = 0; b_re = 0; clr_req = 0;
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, b};
    endfunction

    task automatic fill();
        for (int i = 0; i < int'(DEPTH); i++) begin
            a_we = 1; a_addr = AW'(i); a_wdata = pat(i);
            tick();
        end
        a_we = 0;
    endtask

    initial begin
        int busy_cnt;
        rst = 1; idle_in();
        a_addr = '0; b_addr = '0; a_wdata = '0;
`ifdef DM_BYTE_WE_EN
        a_be = '1;
`endif
        repeat (3) tick();
        cmp("rst_a_rdata", 32'(a_rdata), 32'h0);
        cmp("rst_b_rdata", 32'(b_rdata), 32'h0);
        cmp("rst_a_err",   32'(a_err),   32'h0);
        cmp("rst_busy",    32'(busy),    32'h0);
        cmp("rst_done",    32'(clr_done), 32'h0);
        chk_en = 1;
        rst = 0;
        fill();

        // write then read back
        a_we = 1; a_addr = 5'd5; a_wdata = 16'hBEEF; tick();
        a_we = 0; a_re = 1; tick(); a_re = 0;
        cmp("t1_read", 32'(a_rdata), 32'hBEEF);

        // same-edge write/B-read forwarding
        a_we = 1; a_addr = 5'd16; a_wdata = 16'h1234; b_re = 1; b_addr = 5'd16; tick();
        cmp("t2_fwd", 32'(b_rdata), 32'h1234);
        a_we = 0; b_addr = 5'd17; tick(); b_re = 0;
        cmp("t2_other", 32'(b_rdata), 32'h1111);

        // conflicting request
        a_re = 1; a_we = 1; a_addr = 5'd5; a_wdata = 16'h0000; tick();
        cmp("t3_err", 32'(a_err), 32'h1);
        cmp("t3_hold", 32'(a_rdata), 32'hBEEF);
        a_re = 0; a_we = 0; tick();
        cmp("t3_err_pulse", 32'(a_err), 32'h0);
        a_re = 1; a_addr = 5'd4; tick();
        a_addr = 5'd5; tick(); a_re = 0;
        cmp("t3_mem_kept", 32'(a_rdata), 32'hBEEF);

        // out of range
        a_we = 1; a_addr = 5'd20; a_wdata = 16'hDEAD; tick();
        cmp("oor_wr_err", 32'(a_err), 32'h0);
        a_we = 0; a_re = 1; tick();
        cmp("oor_rd", 32'(a_rdata), 32'h0);
        cmp("oor_rd_err", 32'(a_err), 32'h0);
        a_addr = 5'd19; tick();
        cmp("last_word", 32'(a_rdata), 32'h1313);
        a_addr = 5'd31; b_re = 1; b_addr = 5'd31; tick();
        cmp("oor_rd_top", 32'(a_rdata), 32'h0);
        cmp("oor_b_rd", 32'(b_rdata), 32'h0);
        a_addr = 5'd4; tick(); a_re = 0; b_re = 0;
        cmp("no_alias", 32'(a_rdata), 32'h0404);

        // full clear; port A on the request edge is still served
        a_re = 1; a_addr = 5'd5; tick(); a_re = 0;
        clr_req = 1; a_re = 1; a_addr = 5'd4; tick();
        clr_req = 0; a_re = 0;
        cmp("clr_start_busy", 32'(busy), 32'h1);
        cmp("clr_start_rd", 32'(a_rdata), 32'h0404);
        busy_cnt = 1;
        for (int k = 1; k <= int'(DEPTH); k++) begin
            b_re = 1;
            b_addr = (k % 2 == 1) ? AW'(k - 1) : AW'((k + 2 < int'(DEPTH)) ? k + 2 : int'(DEPTH) - 1);
            if (k == 3) begin a_we = 1; a_addr = 5'd0; a_wdata = 16'h7777; end
            if (k == 4) begin a_re = 1; a_addr = 5'd1; end
            if (k == 7) clr_req = 1;
            tick();
            a_we = 0; a_re = 0; clr_req = 0;
            if (k == 3) cmp("clr_a_blocked", 32'(a_err), 32'h1);
            if (busy) busy_cnt++;
            if (busy_cnt > int'(DEPTH) + 4) break;
        end
        cmp("busy_cycles", 32'(busy_cnt), 32'(DEPTH));
        cmp("clr_done_pulse", 32'(clr_done), 32'h1);
        cmp("busy_off", 32'(busy), 32'h0);
        b_re = 0; a_we = 1; a_addr = 5'd2; a_wdata = 16'h2222; tick(); a_we = 0;
        cmp("clr_done_end", 32'(clr_done), 32'h0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            a_re = 1; a_addr = AW'(i); b_re = 1; b_addr = AW'(int'(DEPTH) - 1 - i);
            tick();
            cmp("clr_word", 32'(a_rdata), (i == 2) ? 32'h2222 : 32'hA5A5);
        end
        idle_in();

        // reset in the middle of a clear
        fill();
        clr_req = 1; tick(); clr_req = 0;
        repeat (8) tick();
        rst = 1; tick(); rst = 0;
        cmp("rst_mid_busy", 32'(busy), 32'h0);
        cmp("rst_mid_done", 32'(clr_done), 32'h0);
        repeat (3) tick();
        for (int i = 0; i < int'(DEPTH); i++) begin
            a_re = 1; a_addr = AW'(i); b_re = 1; b_addr = AW'(i);
            tick();
            cmp("part_clr", 32'(a_rdata), (i < 8) ? 32'hA5A5 : 32'(pat(i)));
        end
        idle_in();

`ifdef DM_BYTE_WE_EN
        a_we = 1; a_addr = 5'd3; a_wdata = 16'hBEEF; a_be = 2'b11; tick();
        a_wdata = 16'h1234; a_be = 2'b01; tick();
        a_we = 0; a_re = 1; tick(); a_re = 0;
        cmp("be_low", 32'(a_rdata), 32'hBE34);
        a_we = 1; a_wdata = 16'h5555; a_be = 2'b00; tick();
        cmp("be_none_err", 32'(a_err), 32'h0);
        a_we = 0; a_re = 1; tick(); a_re = 0;
        cmp("be_none", 32'(a_rdata), 32'hBE34);
        a_we = 1; a_wdata = 16'h9900; a_be = 2'b10; b_re = 1; b_addr = 5'd3; tick();
        a_we = 0; b_re = 0; a_be = 2'b11;
        cmp("be_fwd", 32'(b_rdata), 32'h9934);
`endif
        tick();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
